pwm_step_scheduler: RTL and testbench
=====================================

Name: pwm_step_scheduler

Overview:
Controller that sequences the PWM datapath from the clk_50M domain. It holds an 8-entry duty table written by the host and divides clk_50M by DIV to form a 3.125 MHz tick enable (no derived clock). It builds a 100-tick PWM period and steps through the table, holding each entry for a programmable number of periods. It then finishes or loops. It sits between host/config logic and the motor/LED PWM pin and is the single owner of the PWM output.

Parameters:
DIV, 16, clk_50M cycles per tick; default gives a 3.125 MHz tick.
PERIOD, 100, ticks per PWM period; duty is expressed in ticks, 0..PERIOD.
DEPTH, 8, duty table entries; the index is 3 bits.

Ports:
clk_50M  in  1  system clock, 50 MHz.
reset  in  1  synchronous, active-high reset.
cfg_we  in  1  table write strobe; honoured only in IDLE.
cfg_addr  in  3  table write index.
cfg_duty  in  7  table write data, in ticks.
last_idx  in  3  final step index; sampled at start.
dwell  in  8  periods per step; sampled at start; 0 is treated as 1.
loop_en  in  1  wrap to step 0 after last_idx; sampled at start.
start  in  1  begin the sequence; a one-cycle pulse.
stop  in  1  request a halt; honoured at the next period boundary.
busy  out  1  high in LOAD, RUN and DONE.
step_idx  out  3  current table index.
duty_cur  out  7  duty applied in the current period.
period_start  out  1  one-cycle pulse on the first clk_50M cycle of each period.
pwm_out  out  1  PWM output; registered.
done  out  1  one-cycle pulse on sequence completion or stop.

Behaviour:
- Reset (synchronous, any state, including mid-sequence):
  - state=IDLE; all outputs 0.
  - Prescaler, tick position, dwell counter and latched config are cleared.
  - The table is NOT cleared.
- Prescaler: counts 0..DIV-1 only in RUN; tick=1 when the count is DIV-1. It is reset to 0 in LOAD.
- Tick position pos: counts 0..PERIOD-1 and advances on each tick, wrapping at PERIOD-1 (the period boundary). One period is DIV*PERIOD = 1600 clk_50M cycles.
- pwm_out is registered. It equals (pos < duty_cur) in RUN and is 0 in every other state. duty 0 gives constant low; duty >= PERIOD is clamped to PERIOD (constant high).
- duty_cur changes only at a period boundary or in LOAD, so no partial periods occur.
- FSM:
  - IDLE: table writes are accepted. start=1 -> LOAD; last_idx, dwell and loop_en are latched.
  - LOAD (1 cycle): step_idx=0; duty_cur=clamp(table[0]); pos=0; dwell counter=0. Then -> RUN.
  - RUN, at each period boundary:
    - If stop is pending -> DONE.
    - Else, if the dwell count reaches the latched dwell (after incrementing), the dwell counter is reset and:
      - step_idx != last_idx: step_idx+1, load the new duty.
      - step_idx == last_idx with loop_en: step_idx=0, load table[0].
      - step_idx == last_idx without loop_en: -> DONE.
  - DONE (1 cycle): done=1, pwm_out=0 -> IDLE.
- Latency:
  - start at cycle T: LOAD at T+1, RUN at T+2.
  - pwm_out high at T+3 if duty>0.
  - period_start pulses at T+2, then every 1600 cycles.
- stop is sticky once seen in RUN, until the boundary is reached. stop in IDLE is ignored.
- Simultaneous start and stop in IDLE: start wins. The stop is discarded.
- start while busy is ignored. cfg_we while busy is ignored, so the table is stable during a run.
- last_idx=0: a single-step sequence.

Optional Feature:
Macro PWM_SOFT_RAMP_EN.
- Defined: at each period boundary in RUN, duty_cur moves 1 tick toward the current step's target instead of jumping. LOAD still sets table[0] directly. The dwell count starts only once duty_cur equals the target.
- Undefined: duty_cur jumps to the target immediately. There is no ramp logic.

Test Plan:
- Reset mid-RUN (duty 50) -> the next cycle shows busy=0, pwm_out=0, step_idx=0, and table contents are retained (a re-run shows the same duties).
- table[0]=25, last_idx=0, dwell=1, loop_en=0, start -> pwm_out high 400 cycles then low 1200 cycles; done pulses 1 cycle after the first boundary; busy falls.
- table={10,50,90}, last_idx=2, dwell=2 -> duty_cur sequence 10,10,50,50,90,90 over 9600 cycles, then done; step_idx 0->1->2.
- loop_en=1, same table, then stop asserted mid-period of step 1 -> the period completes; pwm_out=0 thereafter; done pulses once.
- Edge duties 0, 100 and 127 -> constant low, constant high, constant high (clamp); dwell=0 behaves as 1; start and cfg_we during RUN have no effect.
- With PWM_SOFT_RAMP_EN, table={0,5}, dwell=1 -> duty_cur 0 then 1,2,3,4,5 at successive boundaries, then one dwell period at 5.

Source files
------------

// File: rtl/pwm_step_scheduler_if.sv
// Host-side bundle for pwm_step_scheduler: duty-table writes, sequence control and PWM status.
interface pwm_step_scheduler_if;
    logic       cfg_we;
    logic [2:0] cfg_addr;
    logic [6:0] cfg_duty;
    logic [2:0] last_idx;
    logic [7:0] dwell;
    logic       loop_en;
    logic       start;
    logic       stop;

    logic       busy;
    logic [2:0] step_idx;
    logic [6:0] duty_cur;
    logic       period_start;
    logic       pwm_out;
    logic       done;

    modport master (
        output cfg_we, cfg_addr, cfg_duty, last_idx, dwell, loop_en, start, stop,
        input  busy, step_idx, duty_cur, period_start, pwm_out, done
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_duty, last_idx, dwell, loop_en, start, stop,
        output busy, step_idx, duty_cur, period_start, pwm_out, done
    );
endinterface

// File: rtl/pwm_step_scheduler.sv
// Duty-table sequencer: DIV-prescaled tick enable, PERIOD-tick PWM frame, dwell periods per step.
// Define PWM_SOFT_RAMP_EN to slew duty_cur one tick per period toward each step's target.
module pwm_step_scheduler #(
    parameter int DIV    = 16,
    parameter int PERIOD = 100,
    parameter int DEPTH  = 8
) (
    input  logic                clk_50M,
    input  logic                reset,
    pwm_step_scheduler_if.slave bus
);
    localparam int IW = 3;
    localparam int DW = 7;
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int QW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [QW-1:0] POS_LAST   = QW'(PERIOD - 1);
    localparam logic [DW-1:0] DUTY_MAX   = DW'(PERIOD);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]    state;
    logic [DW-1:0] table_mem [DEPTH];

    logic [PW-1:0] presc;
    logic [QW-1:0] pos;
    logic [7:0]    dwell_cnt;
    logic [7:0]    dwell_lat;
    logic [IW-1:0] last_lat;
    logic          loop_lat;
    logic          stop_pend;

    logic [IW-1:0] step_idx;
    logic [DW-1:0] duty_cur;
    logic          period_start;
    logic          pwm_out;

    logic          tick;
    logic          boundary;
    logic          halt;
    logic          dwell_hit;
    logic          at_last;
    logic          settled;
    logic          finish;
    logic [IW-1:0] step_nxt;
    logic [DW-1:0] duty_hold;
    logic [DW-1:0] duty_adv;

    function automatic logic [DW-1:0] clamp_duty(input logic [DW-1:0] d);
        return (d > DUTY_MAX) ? DUTY_MAX : d;
    endfunction

`ifdef PWM_SOFT_RAMP_EN
    function automatic logic [DW-1:0] step_toward(input logic [DW-1:0] cur,
                                                  input logic [DW-1:0] tgt);
        if (cur < tgt)
            return cur + 1'b1;
        else if (cur > tgt)
            return cur - 1'b1;
        else
            return cur;
    endfunction
`endif

    assign tick      = (state == S_RUN) && (presc == PRESC_LAST);
    assign boundary  = tick && (pos == POS_LAST);
    assign halt      = stop_pend | bus.stop;
    assign dwell_hit = ((dwell_cnt + 8'd1) == dwell_lat);
    assign at_last   = (step_idx == last_lat);
    assign step_nxt  = at_last ? '0 : step_idx + 1'b1;

`ifdef PWM_SOFT_RAMP_EN
    logic [DW-1:0] tgt_cur;
    assign tgt_cur   = clamp_duty(table_mem[step_idx]);
    // Dwell only accumulates once the ramp has landed on the step's target.
    assign settled   = (duty_cur == tgt_cur);
    assign duty_hold = step_toward(duty_cur, tgt_cur);
    assign duty_adv  = step_toward(duty_cur, clamp_duty(table_mem[step_nxt]));
`else
    assign settled   = 1'b1;
    assign duty_hold = duty_cur;
    assign duty_adv  = clamp_duty(table_mem[step_nxt]);
`endif

    assign finish = boundary && (halt || (settled && dwell_hit && at_last && !loop_lat));

    // Table survives reset; writes are locked out while a sequence owns it.
    always_ff @(posedge clk_50M) begin
        if (state == S_IDLE && bus.cfg_we)
            table_mem[bus.cfg_addr] <= bus.cfg_duty;
    end

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            state        <= S_IDLE;
            presc        <= '0;
            pos          <= '0;
            dwell_cnt    <= '0;
            dwell_lat    <= '0;
            last_lat     <= '0;
            loop_lat     <= 1'b0;
            stop_pend    <= 1'b0;
            step_idx     <= '0;
            duty_cur     <= '0;
            period_start <= 1'b0;
            pwm_out      <= 1'b0;
        end else begin
            period_start <= 1'b0;
            pwm_out      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state     <= S_LOAD;
                        last_lat  <= bus.last_idx;
                        dwell_lat <= (bus.dwell == 8'd0) ? 8'd1 : bus.dwell;
                        loop_lat  <= bus.loop_en;
                    end
                end
                S_LOAD: begin
                    step_idx     <= '0;
                    duty_cur     <= clamp_duty(table_mem[3'd0]);
                    presc        <= '0;
                    pos          <= '0;
                    dwell_cnt    <= '0;
                    stop_pend    <= 1'b0;
                    period_start <= 1'b1;
                    state        <= S_RUN;
                end
                S_RUN: begin
                    // The sample taken on the terminating boundary is dropped so DONE is low.
                    pwm_out <= (pos < duty_cur) && !finish;
                    presc   <= tick ? '0 : presc + 1'b1;
                    if (bus.stop)
                        stop_pend <= 1'b1;
                    if (tick)
                        pos <= (pos == POS_LAST) ? '0 : pos + 1'b1;
                    if (boundary) begin
                        if (finish) begin
                            state <= S_DONE;
                        end else begin
                            period_start <= 1'b1;
                            if (!settled) begin
                                duty_cur <= duty_hold;
                            end else if (dwell_hit) begin
                                dwell_cnt <= '0;
                                step_idx  <= step_nxt;
                                duty_cur  <= duty_adv;
                            end else begin
                                dwell_cnt <= dwell_cnt + 8'd1;
                            end
                        end
                    end
                end
                default: begin
                    stop_pend <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy         = (state != S_IDLE);
    assign bus.done         = (state == S_DONE);
    assign bus.step_idx     = step_idx;
    assign bus.duty_cur     = duty_cur;
    assign bus.period_start = period_start;
    assign bus.pwm_out      = pwm_out;

endmodule

// File: tb/tb_pwm_step_scheduler.sv
// Scoreboard bench for pwm_step_scheduler: expected periods queued at launch, checked per period_start.
module tb_pwm_step_scheduler;
    localparam int DIV    = 16;
    localparam int PERIOD = 100;
    localparam int PCYC   = DIV * PERIOD;

    logic clk_50M = 1'b0;
    logic reset   = 1'b1;

    pwm_step_scheduler_if bus();

    pwm_step_scheduler #(.DIV(DIV), .PERIOD(PERIOD), .DEPTH(8)) dut (
        .clk_50M (clk_50M),
        .reset   (reset),
        .bus     (bus)
    );

    always #10 clk_50M = ~clk_50M;

    typedef struct {
        int step;
        int duty;
        int highs;
    } per_t;

    per_t exp_q[$];
    per_t cur;
    int   tb_tab[8];
    int   checks    = 0;
    int   errors    = 0;
    int   done_seen = 0;
    int   ncyc      = 0;
    int   win_k     = 0;
    int   hi_cnt    = 0;
    bit   win_on    = 1'b0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int clampd(input int d);
        return (d > PERIOD) ? PERIOD : d;
    endfunction

    task automatic exp_step(input int s, input int reps);
        per_t e;
        for (int r = 0; r < reps; r++) begin
            e.step  = s;
            e.duty  = clampd(tb_tab[s]);
            // pwm lags pos by one cycle; the window covers the first PCYC-1 samples
            e.highs = (e.duty * DIV < PCYC - 1) ? e.duty * DIV : PCYC - 1;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: one expected entry per period_start, pwm high count over the period.
    always @(negedge clk_50M) begin
        if (reset) begin
            exp_q.delete();
            win_on = 1'b0;
        end else begin
            if (win_on) begin
                win_k++;
                if (bus.pwm_out) hi_cnt++;
                if (win_k == PCYC - 1) begin
                    chk("pwm_high_count", hi_cnt, cur.highs);
                    win_on = 1'b0;
                end
            end
            if (bus.period_start) begin
                chk("period_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    cur = exp_q.pop_front();
                    chk("duty_cur", int'(bus.duty_cur), cur.duty);
                    chk("step_idx", int'(bus.step_idx), cur.step);
                    win_on = 1'b1;
                    win_k  = 0;
                    hi_cnt = 0;
                end
            end
            if (bus.done) begin
                chk("periods_left_at_done", exp_q.size(), 0);
                done_seen++;
            end
        end
    end

    task automatic tick_n(input int n);
        repeat (n) begin
            @(negedge clk_50M);
            ncyc++;
        end
    endtask

    task automatic wr(input int a, input int d);
        @(negedge clk_50M);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 3'(a);
        bus.cfg_duty = 7'(d);
        @(negedge clk_50M);
        bus.cfg_we = 1'b0;
        tb_tab[a]  = d;
    endtask

    task automatic launch(input int last, input int dw, input bit lp, input bit stp);
        @(negedge clk_50M);
        bus.last_idx = 3'(last);
        bus.dwell    = 8'(dw);
        bus.loop_en  = lp;
        bus.start    = 1'b1;
        bus.stop     = stp;
        @(negedge clk_50M);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        ncyc      = 1;
    endtask

    task automatic wait_done(input string tag, input int exp_n);
        while (!bus.done && ncyc < exp_n + 50) tick_n(1);
        chk(tag, ncyc, exp_n);
        tick_n(1);
        chk({tag, "_done_width"}, int'(bus.done), 0);
        chk({tag, "_busy_after"}, int'(bus.busy), 0);
    endtask

    initial begin
        #(60000 * 20);
        $display("FAIL watchdog: got no finish, expected finish within 60000 cycles");
        $fatal(1);
    end

    initial begin
        int d0;
        int hi;
        bus.cfg_we   = 1'b0;
        bus.cfg_addr = '0;
        bus.cfg_duty = '0;
        bus.last_idx = '0;
        bus.dwell    = '0;
        bus.loop_en  = 1'b0;
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        for (int i = 0; i < 8; i++) tb_tab[i] = 0;

        tick_n(3);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_pwm", int'(bus.pwm_out), 0);
        chk("rst_step", int'(bus.step_idx), 0);
        chk("rst_duty", int'(bus.duty_cur), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_pstart", int'(bus.period_start), 0);
        reset = 1'b0;
        tick_n(2);

        // Single step, duty 25: latency and one-period run
        wr(0, 25);
        exp_step(0, 1);
        launch(0, 1, 1'b0, 1'b0);
        chk("a_busy_t1", int'(bus.busy), 1);
        tick_n(1);
        chk("a_pstart_t2", int'(bus.period_start), 1);
        chk("a_pwm_t2", int'(bus.pwm_out), 0);
        tick_n(1);
        chk("a_pwm_t3", int'(bus.pwm_out), 1);
        wait_done("a_done_cycle", 2 + PCYC);

        // Three steps, dwell 2; start and cfg_we mid-run must be ignored
        wr(0, 10);
        wr(1, 50);
        wr(2, 90);
        exp_step(0, 2);
        exp_step(1, 2);
        exp_step(2, 2);
        launch(2, 2, 1'b0, 1'b0);
        tick_n(3000 - ncyc);
        bus.start    = 1'b1;
        bus.last_idx = 3'd0;
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 3'd1;
        bus.cfg_duty = 7'd0;
        tick_n(1);
        bus.start  = 1'b0;
        bus.cfg_we = 1'b0;
        wait_done("b_done_cycle", 2 + 6 * PCYC);

        // Looping run, stop mid-period on the second pass through step 1
        d0 = done_seen;
        exp_step(0, 2);
        exp_step(1, 2);
        exp_step(2, 2);
        exp_step(0, 2);
        exp_step(1, 1);
        launch(2, 2, 1'b1, 1'b0);
        tick_n(2 + 8 * PCYC + PCYC / 2 - ncyc);
        bus.stop = 1'b1;
        tick_n(1);
        bus.stop = 1'b0;
        wait_done("c_done_cycle", 2 + 9 * PCYC);
        hi = 0;
        repeat (20) begin
            tick_n(1);
            if (bus.pwm_out) hi++;
        end
        chk("c_pwm_after_stop", hi, 0);
        chk("c_done_pulses", done_seen - d0, 1);

        // Edge duties, dwell 0 acts as 1, stop together with start is discarded
        wr(0, 0);
        wr(1, 100);
        wr(2, 127);
        exp_step(0, 1);
        exp_step(1, 1);
        exp_step(2, 1);
        launch(2, 0, 1'b0, 1'b1);
        wait_done("d_done_cycle", 2 + 3 * PCYC);

        // Reset mid-run, then a re-run shows the table was kept
        wr(0, 50);
        wr(1, 100);
        exp_step(0, 1);
        exp_step(1, 1);
        launch(1, 1, 1'b0, 1'b0);
        tick_n(2000 - ncyc);
        chk("e_step_before_reset", int'(bus.step_idx), 1);
        reset = 1'b1;
        tick_n(1);
        chk("e_rst_busy", int'(bus.busy), 0);
        chk("e_rst_pwm", int'(bus.pwm_out), 0);
        chk("e_rst_step", int'(bus.step_idx), 0);
        chk("e_rst_duty", int'(bus.duty_cur), 0);
        chk("e_rst_done", int'(bus.done), 0);
        tick_n(1);
        reset = 1'b0;
        tick_n(2);
        chk("e_queue_flushed", exp_q.size(), 0);
        exp_step(0, 1);
        exp_step(1, 1);
        exp_step(2, 1);
        launch(2, 1, 1'b0, 1'b0);
        wait_done("e_rerun_done", 2 + 3 * PCYC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
